// File: rtl/sysbus_pkg.sv
// Shared system-bus types and constants: arbiter state, bus owner encoding
// and the well-known bus command/tag values.
package sysbus_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GRANT,
      ARB_BUSY,
      ARB_TURN
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE   = 2'd0,
      OWN_ICACHE = 2'd1,
      OWN_DCACHE = 2'd2
   } owner_t;

   localparam logic [1:0]  SYSBUS_READ           = 2'd1;
   localparam logic [1:0]  SYSBUS_WRITE          = 2'd2;
   localparam logic [12:0] SYSBUS_MEMORY         = 13'h0000;
   localparam logic [12:0] SYSBUS_INVALIDATE_TAG = 13'h0800;

endpackage

// File: rtl/arb_pick2.sv
// Combinational winner select between the two cache requesters, either with
// fixed dcache priority or round-robin against the previous owner.
module arb_pick2
   import sysbus_pkg::*;
#(
   parameter bit DCACHE_PRIORITY = 1'b1
) (
   input  logic [1:0] reqs,
   input  logic [1:0] last_owner,
   output logic [1:0] winner
);

   // reqs[0] is the icache, reqs[1] the dcache
   always_comb begin
      winner = OWN_NONE;
      case (reqs)
         2'b01:   winner = OWN_ICACHE;
         2'b10:   winner = OWN_DCACHE;
         2'b11:   winner = (DCACHE_PRIORITY || (last_owner == OWN_ICACHE)) ? OWN_DCACHE : OWN_ICACHE;
         default: winner = OWN_NONE;
      endcase
   end

endmodule

// File: rtl/sysbus_arbiter.sv
// Grants the single system bus to the icache or dcache, revokes grants left
// unused too long, and holds off new grants during snoop-invalidate responses.
module sysbus_arbiter
   import sysbus_pkg::*;
#(
   parameter int          GRANT_TIMEOUT   = 16,
   parameter bit          DCACHE_PRIORITY = 1'b1,
   parameter logic [12:0] INV_TAG         = SYSBUS_INVALIDATE_TAG
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        icache_busreq,
   input  logic        icache_busidle,
   output logic        icache_busgrant,
   input  logic        dcache_busreq,
   input  logic        dcache_busidle,
   output logic        dcache_busgrant,
   input  logic        bus_respcyc,
   input  logic [12:0] bus_resptag,
   output logic [1:0]  bus_owner,
   output logic        bus_revoked
);

   localparam logic [7:0] TMO_LAST = 8'(GRANT_TIMEOUT - 1);

   arb_state_t state;
   owner_t     owner;
   owner_t     last_owner;
   logic [1:0] winner;
   logic [7:0] tmo_cnt;
   logic       owner_idle;
   logic       snoop_inv;

   arb_pick2 #(
      .DCACHE_PRIORITY(DCACHE_PRIORITY)
   ) u_pick (
      .reqs      ({dcache_busreq, icache_busreq}),
      .last_owner(last_owner),
      .winner    (winner)
   );

   // Only the current owner's busidle matters; the other side is ignored.
   assign owner_idle = (owner == OWN_DCACHE) ? dcache_busidle : icache_busidle;
   assign snoop_inv  = bus_respcyc && (bus_resptag == INV_TAG);
   assign bus_owner  = owner;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= ARB_IDLE;
         owner           <= OWN_NONE;
         last_owner      <= OWN_ICACHE;
         tmo_cnt         <= '0;
         icache_busgrant <= 1'b0;
         dcache_busgrant <= 1'b0;
         bus_revoked     <= 1'b0;
      end else begin
         bus_revoked <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (!snoop_inv && (winner != OWN_NONE)) begin
                  state           <= ARB_GRANT;
                  owner           <= owner_t'(winner);
                  tmo_cnt         <= '0;
                  icache_busgrant <= (winner == OWN_ICACHE);
                  dcache_busgrant <= (winner == OWN_DCACHE);
               end
            end
            ARB_GRANT: begin
               if (!owner_idle) begin
                  state           <= ARB_BUSY;
                  tmo_cnt         <= '0;
                  icache_busgrant <= 1'b0;
                  dcache_busgrant <= 1'b0;
               end else if (tmo_cnt >= TMO_LAST) begin
                  // Revocation leaves last_owner alone so the idle side keeps its turn.
                  state           <= ARB_TURN;
                  owner           <= OWN_NONE;
                  tmo_cnt         <= '0;
                  bus_revoked     <= 1'b1;
                  icache_busgrant <= 1'b0;
                  dcache_busgrant <= 1'b0;
               end else if (tmo_cnt != 8'hFF) begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            ARB_BUSY: begin
               if (owner_idle) begin
                  state      <= ARB_TURN;
                  last_owner <= owner;
                  owner      <= OWN_NONE;
               end
            end
            ARB_TURN: state <= ARB_IDLE;
            default:  state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: doc/sysbus_arbiter.md
Name: sysbus_arbiter

Overview:
- Shares the single system bus (bus_req/bus_reqtag/bus_reqcyc/bus_respack) between the instruction cache and the data cache.
- Each cache raises busreq on a miss or a dirty writeback, waits for busgrant, then drives its bus transaction, holding busidle low until done.
- The arbiter also drives the owner select for the top-level bus mux and defers new grants during snoop-invalidate responses.

Parameters:
GRANT_TIMEOUT, 16, cycles a grant may stay unused (owner busidle still 1) before it is revoked; range 1..255
DCACHE_PRIORITY, 1, 1 = dcache wins every simultaneous request; 0 = round-robin on last owner
INV_TAG, 13'h0800, bus_resptag value marking a snoop-invalidate response

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-low reset
icache_busreq  input  1  icache requests bus ownership
icache_busidle  input  1  1 = icache not driving a bus transaction
icache_busgrant  output  1  grant to icache
dcache_busreq  input  1  dcache requests bus ownership
dcache_busidle  input  1  1 = dcache not driving a bus transaction
dcache_busgrant  output  1  grant to dcache
bus_respcyc  input  1  response valid on system bus
bus_resptag  input  13  response tag
bus_owner  output  2  0 none, 1 icache, 2 dcache; top-level bus mux select
bus_revoked  output  1  one-cycle pulse when a grant times out

Behaviour:
- Reset (reset==0, async) forces the following:
  - all outputs 0; state ARB_IDLE; timeout counter 0
  - last_owner = ICACHE, so round-robin favours dcache first
- All outputs are registered.
- States and transitions:
  - ARB_IDLE: latch winner among busreq inputs -> ARB_GRANT. That cycle: grant[winner]<=1, bus_owner<=winner, counter<=0. No request -> stay.
  - ARB_GRANT: grant held high.
    - owner busidle==0 -> grant<=0, go ARB_BUSY; bus_owner unchanged.
    - Else counter increments. When counter reaches GRANT_TIMEOUT-1 with busidle still 1: grant<=0, bus_owner<=0, bus_revoked pulses, go ARB_TURN.
    - Owner busreq is ignored in this state, because caches drop busreq on seeing grant.
  - ARB_BUSY: wait for owner busidle==1 -> bus_owner<=0, last_owner<=owner, go ARB_TURN.
  - ARB_TURN: one bus turnaround cycle, no grant -> ARB_IDLE.
- Latency:
  - busreq high at edge N (state IDLE) -> busgrant high after edge N+1.
  - Release-to-next-grant is minimum 2 cycles (TURN, then IDLE sampling).
- Arbitration (both busreq high in ARB_IDLE):
  - DCACHE_PRIORITY=1 -> dcache.
  - Otherwise the requester != last_owner wins.
  - A single requester always wins.
- Snoop deferral: in ARB_IDLE, if bus_respcyc==1 && bus_resptag==INV_TAG, no grant is issued that cycle; the state stays ARB_IDLE.
- Invariants:
  - grants are one-hot or zero, never both.
  - bus_owner is nonzero from grant through release.
  - Non-owner busidle toggles are ignored.
- Timeout counter is 8 bits and saturates; it is only live in ARB_GRANT.
- Revocation does not update last_owner.
- Reset mid-ARB_BUSY drops ownership immediately; the caches are reset by the same signal.

Decomposition:
- Shared package sysbus_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_GRANT, ARB_BUSY, ARB_TURN}
  - owner_t encoding {OWN_NONE=0, OWN_ICACHE=1, OWN_DCACHE=2}
  - SYSBUS_INVALIDATE_TAG = 13'h0800, alongside the existing SYSBUS_READ/WRITE/MEMORY constants
- Optional sub-module arb_pick2: a combinational winner select from (reqs, last_owner, DCACHE_PRIORITY).
- The FSM and timeout stay in the top module.

Test Plan:
- Single dcache request: dcache_busreq=1 at cycle 2.
  - Required: dcache_busgrant=1 and bus_owner=2 at cycle 3.
  - Then busidle=0 at cycle 4: grant=0 at cycle 5, bus_owner held.
  - Then busidle=1 at cycle 12: bus_owner=0 at cycle 13, next grant no earlier than cycle 15.
- Simultaneous requests, DCACHE_PRIORITY=0, both busreq held:
  - grants alternate dcache, icache, dcache across three complete transactions.
  - With DCACHE_PRIORITY=1, dcache wins all three.
- Grant never used: icache granted, icache_busidle stays 1.
  - After GRANT_TIMEOUT=16 cycles: grant=0, bus_revoked=1 for exactly one cycle, bus_owner=0.
  - Pending dcache request is granted 2 cycles later.
- Snoop deferral: dcache_busreq=1 in the same cycle as bus_respcyc=1, bus_resptag=13'h0800.
  - No grant that cycle; grant is asserted one cycle later.
- Reset mid-operation: reset driven 0 during ARB_BUSY.
  - Grants and bus_owner go to 0 without waiting for clk.
  - After release, simultaneous requests grant dcache first.
- Invariant check: random busreq/busidle traffic for 10k cycles.
  - Assertions: grants never both 1; bus_owner matches the granted side; no grant while the other side is ARB_BUSY owner.
